// File: rtl/cnn_pkg.sv
// Shared definitions for the systolic-array output path: geometry, widths,
// collector FSM encoding and the sum-to-output narrowing function.
// Optional feature: define OUT_SAT_EN to saturate sums instead of wrapping them.
package cnn_pkg;

    localparam int DW    = 16;              // lane / result width (signed)
    localparam int IMG   = 7;               // output feature-map side
    localparam int PAD   = 1;               // input padding
    localparam int SIZE  = IMG + 2*PAD;     // padded columns per row
    localparam int NPIX  = IMG * IMG;       // results per frame
    localparam int SW    = DW + 2;          // width of the three-lane sum
    localparam int COL_W = $clog2(SIZE);
    localparam int ROW_W = $clog2(IMG + 1); // must also hold IMG after the last row wraps
    localparam int IDX_W = $clog2(NPIX);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FULL    = 2'd2,
        ST_READ    = 2'd3
    } state_t;

    // Narrow a three-lane sum to the output width.
    function automatic logic signed [DW-1:0] fit_dw(input logic signed [SW-1:0] s);
`ifdef OUT_SAT_EN
        // The top SW-DW+1 bits must all match the sign for the value to fit.
        if (s[SW-1:DW-1] != {(SW-DW+1){s[SW-1]}})
            fit_dw = s[SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
            fit_dw = s[DW-1:0];
`else
        fit_dw = s[DW-1:0];
`endif
    endfunction

endpackage

// File: rtl/sa_deskew.sv
// Re-aligns the three row-skewed SA lanes: lane 0 and its valid are delayed
// two cycles, lane 1 one cycle, lane 2 passes straight through, so all three
// values of one padded column appear together with the aligned valid av.
module sa_deskew
    import cnn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 srt_sig,
    input  logic signed [DW-1:0] in1,
    input  logic signed [DW-1:0] in2,
    input  logic signed [DW-1:0] in3,
    output logic                 av,
    output logic signed [DW-1:0] a1,
    output logic signed [DW-1:0] a2,
    output logic signed [DW-1:0] a3
);

    logic [1:0]           vld_q;
    logic signed [DW-1:0] l0_q0, l0_q1;
    logic signed [DW-1:0] l1_q0;

    // Delay lines; a new frame (clr) discards whatever is in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst || clr) begin
            vld_q <= '0;
            l0_q0 <= '0;
            l0_q1 <= '0;
            l1_q0 <= '0;
        end else begin
            vld_q <= {vld_q[0], srt_sig};
            l0_q0 <= in1;
            l0_q1 <= l0_q0;
            l1_q0 <= in2;
        end
    end

    assign av = vld_q[1];
    assign a1 = l0_q1;
    assign a2 = l1_q0;
    assign a3 = in3;

endmodule

// File: rtl/sa_output_collector.sv
// Far end of the SA stream: de-skews and sums the three lanes into one result
// per padded column, drops the warm-up columns, buffers an IMG x IMG frame and
// streams it out row-major under valid/ready.
// Optional feature: OUT_SAT_EN selects saturating instead of wrapping sums.
module sa_output_collector
    import cnn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 srt_sig,
    input  logic signed [DW-1:0] in1,
    input  logic signed [DW-1:0] in2,
    input  logic signed [DW-1:0] in3,
    input  logic                 rd_req,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_data,
    output logic                 frame_rdy,
    output logic                 done,
    output logic                 ovf
);

    state_t state_q, state_d;

    logic                 av;
    logic signed [DW-1:0] a1, a2, a3;
    logic signed [SW-1:0] sum;

    logic [COL_W-1:0]     col_q;
    logic [ROW_W-1:0]     row_q;

    logic                 wr_en_q, wr_last_q;
    logic [IDX_W-1:0]     wr_addr_q;
    logic signed [DW-1:0] wr_data_q;

    logic signed [DW-1:0] buf_mem [NPIX];

    logic [IDX_W-1:0]     rd_idx_q;
    logic signed [DW-1:0] out_data_q;
    logic                 done_q, ovf_q;

    logic collecting, take, keep, hs, rd_start, rd_last, store_last, col_end;

    sa_deskew u_deskew (
        .clk     (clk),
        .rst     (rst),
        .clr     (load),
        .srt_sig (srt_sig),
        .in1     (in1),
        .in2     (in2),
        .in3     (in3),
        .av      (av),
        .a1      (a1),
        .a2      (a2),
        .a3      (a3)
    );

    assign sum        = SW'(a1) + SW'(a2) + SW'(a3);
    assign collecting = (state_q == ST_COLLECT);
    // load wins over a coincident aligned sample
    assign take       = av && collecting && !load;
    assign col_end    = (col_q == COL_W'(SIZE - 1));
    assign keep       = take && (col_q >= COL_W'(2)) && (row_q < ROW_W'(IMG));
    assign hs         = out_valid && out_ready;
    assign rd_start   = (state_q == ST_FULL) && rd_req && !load;
    assign rd_last    = hs && (rd_idx_q == IDX_W'(NPIX - 1));
    assign store_last = wr_en_q && wr_last_q && !load;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic; load restarts collection from any state
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        if (load) begin
            state_d = ST_COLLECT;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_IDLE;
                ST_COLLECT: if (store_last) state_d = ST_FULL;
                ST_FULL:    if (rd_req)     state_d = ST_READ;
                ST_READ:    if (rd_last)    state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs decoded from the current state
    always_comb begin
        out_valid = (state_q == ST_READ);
        frame_rdy = (state_q == ST_FULL);
    end

    // Padded column / row position of the next aligned sample
    always_ff @(posedge clk) begin
        if (rst || load) begin
            col_q <= '0;
            row_q <= '0;
        end else if (take) begin
            if (col_end) begin
                col_q <= '0;
                row_q <= row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

    // Registered sum plus its destination, written one cycle after av
    always_ff @(posedge clk) begin
        if (rst || load) begin
            wr_en_q   <= 1'b0;
            wr_last_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= keep;
            wr_last_q <= col_end && (row_q == ROW_W'(IMG - 1));
            wr_addr_q <= IDX_W'(row_q) * IDX_W'(IMG) + IDX_W'(col_q) - IDX_W'(2);
            wr_data_q <= fit_dw(sum);
        end
    end

    // Result buffer; contents survive load and are simply overwritten
    always_ff @(posedge clk) begin
        // NOTE: the buffer has no reset; every location is written before it can be read.
        if (wr_en_q && !rst && !load)
            buf_mem[wr_addr_q] <= wr_data_q;
    end

    // Readout: out_data is the registered buffer word at rd_idx_q, refetched on each handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_idx_q   <= '0;
            out_data_q <= '0;
        end else if (rd_start) begin
            rd_idx_q   <= '0;
            out_data_q <= buf_mem[0];
        end else if (hs && !rd_last && !load) begin
            rd_idx_q   <= rd_idx_q + IDX_W'(1);
            out_data_q <= buf_mem[rd_idx_q + IDX_W'(1)];
        end
    end

    // done pulse after the final handshake; sticky overflow for stray aligned data
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= rd_last && !load;
            if (load)                   ovf_q <= 1'b0;
            else if (av && !collecting) ovf_q <= 1'b1;
        end
    end

    assign out_data = out_data_q;
    assign done     = done_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_sa_output_collector.sv
// Self-checking bench for sa_output_collector: random frames are fed with the
// lane skew applied, a frame-level reference model predicts the stored results,
// and a monitor pops the expected queue on every output handshake.
module tb_sa_output_collector;
    import cnn_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst, load, srt_sig, rd_req, out_ready;
    logic signed [DW-1:0] in1, in2, in3;
    logic                 out_valid, frame_rdy, done, ovf;
    logic signed [DW-1:0] out_data;

    sa_output_collector dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .srt_sig   (srt_sig),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .rd_req    (rd_req),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .frame_rdy (frame_rdy),
        .done      (done),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int exp_q[$];
    int model [IMG][IMG];
    int fx1 [IMG][SIZE];
    int fx2 [IMG][SIZE];
    int fx3 [IMG][SIZE];

    bit exp_done   = 1'b0;
    bit stall_prev = 1'b0;
    int held       = 0;
    int hs_count   = 0;

    // lane history for the skewed driver
    bit p1v = 1'b0, p2v = 1'b0;
    int p1x2 = 0, p1x3 = 0, p2x3 = 0;

    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference narrowing of an exact integer sum
    function automatic int fit(input int s);
        int hi, m;
        hi = 1 << (DW - 1);
`ifdef OUT_SAT_EN
        if (s > hi - 1) return hi - 1;
        if (s < -hi)    return -hi;
        return s;
`else
        m = ((s % (2 * hi)) + 2 * hi) % (2 * hi);
        return (m >= hi) ? m - 2 * hi : m;
`endif
    endfunction

    function automatic int rnd16();
        logic signed [15:0] t;
        t = 16'($urandom);
        return int'(t);
    endfunction

    // One clock of stimulus: lane 0 now, lane 1 of the previous cycle, lane 2 of two cycles ago
    task automatic step(input bit v, input int x1, input int x2, input int x3);
        srt_sig = v;
        in1 = v   ? DW'(x1)   : DW'($urandom);
        in2 = p1v ? DW'(p1x2) : DW'($urandom);
        in3 = p2v ? DW'(p2x3) : DW'($urandom);
        p2v = p1v; p2x3 = p1x3;
        p1v = v;   p1x2 = x2; p1x3 = x3;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 0, 0);
    endtask

    task automatic start_frame();
        load = 1'b1;
        step(1'b0, 0, 0, 0);
        load = 1'b0;
    endtask

    // kind 0: lanes = column index, 1: all ones, 2: random, 3: random with a 0x7000 column
    task automatic make_frame(input int kind);
        for (int r = 0; r < IMG; r++)
            for (int c = 0; c < SIZE; c++) begin
                case (kind)
                    0: begin fx1[r][c] = c; fx2[r][c] = c; fx3[r][c] = c; end
                    1: begin fx1[r][c] = 1; fx2[r][c] = 1; fx3[r][c] = 1; end
                    default: begin fx1[r][c] = rnd16(); fx2[r][c] = rnd16(); fx3[r][c] = rnd16(); end
                endcase
            end
        if (kind == 3) begin
            fx1[2][5] = 28672; fx2[2][5] = 28672; fx3[2][5] = 28672;
            fx1[4][2] = -28672; fx2[4][2] = -28672; fx3[4][2] = -28672;
        end
        for (int r = 0; r < IMG; r++)
            for (int c = 2; c < SIZE; c++)
                model[r][c-2] = fit(fx1[r][c] + fx2[r][c] + fx3[r][c]);
    endtask

    // gap_mode 0: none, 1: five idle cycles mid-row, 2: random gaps
    task automatic stream_frame(input int gap_mode, input bit extra);
        for (int r = 0; r < IMG; r++)
            for (int c = 0; c < SIZE; c++) begin
                if (gap_mode == 1 && r == 3 && c == 4) idle(5);
                if (gap_mode == 2 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                step(1'b1, fx1[r][c], fx2[r][c], fx3[r][c]);
            end
        idle(4);
        if (extra) begin
            step(1'b1, 5, 5, 5);
            idle(4);
        end
    endtask

    // ready_mode 0: always ready, 1: 1,0,0,1 pattern, 2: random; abort_at >= 0 issues load mid-read
    task automatic read_frame(input int ready_mode, input int abort_at);
        bit finished;
        finished = 1'b0;
        check("frame_rdy_before_read", int'(frame_rdy), 1);
        for (int r = 0; r < IMG; r++)
            for (int c = 0; c < IMG; c++)
                exp_q.push_back(model[r][c]);
        hs_count  = 0;
        out_ready = 1'b0;
        rd_req    = 1'b1;
        step(1'b0, 0, 0, 0);
        rd_req    = 1'b0;
        check("valid_after_rd_req", int'(out_valid), 1);
        for (int k = 0; k < 500; k++) begin
            if (exp_q.size() == 0) begin
                finished = 1'b1;
                break;
            end
            if (abort_at >= 0 && hs_count == abort_at) begin
                out_ready = 1'b0;
                load      = 1'b1;
                step(1'b0, 0, 0, 0);
                load      = 1'b0;
                check("abort_out_valid", int'(out_valid), 0);
                check("abort_frame_rdy", int'(frame_rdy), 0);
                exp_q.delete();
                return;
            end
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = pat[k % 4];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            step(1'b0, 0, 0, 0);
        end
        out_ready = 1'b0;
        idle(2);
        check("read_complete", finished ? 0 : exp_q.size(), 0);
        check("idle_out_valid", int'(out_valid), 0);
        check("idle_frame_rdy", int'(frame_rdy), 0);
        exp_q.delete();
    endtask

    // Monitor: compares every handshake against the scoreboard queue
    always @(negedge clk) begin
        if (exp_done) begin
            check("done_pulse", int'(done), 1);
            exp_done = 1'b0;
        end else if (done) begin
            check("unexpected_done", int'(done), 0);
        end
        if (stall_prev && out_valid)
            check("stall_hold", int'(out_data), held);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_output", int'(out_data), 0);
                n_errors++;
                $display("FAIL extra_output: got output with empty scoreboard");
            end else begin
                check("out_data", int'(out_data), exp_q.pop_front());
                hs_count++;
                if (exp_q.size() == 0) exp_done = 1'b1;
            end
        end
        stall_prev = out_valid && !out_ready;
        held       = int'(out_data);
    end

    initial begin
        rst = 1'b1; load = 1'b0; srt_sig = 1'b0; rd_req = 1'b0; out_ready = 1'b0;
        in1 = '0; in2 = '0; in3 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data",  int'(out_data),  0);
        check("rst_frame_rdy", int'(frame_rdy), 0);
        check("rst_done",      int'(done),      0);
        check("rst_ovf",       int'(ovf),       0);

        // rd_req while IDLE is ignored
        rd_req = 1'b1;
        step(1'b0, 0, 0, 0);
        rd_req = 1'b0;
        idle(1);
        check("idle_rd_req_ignored", int'(out_valid), 0);

        // lanes = column index -> stored values 3*(c+2)
        start_frame();
        make_frame(0);
        stream_frame(0, 1'b0);
        check("frame0_ovf", int'(ovf), 0);
        read_frame(0, -1);

        // all-ones frame
        start_frame();
        make_frame(1);
        stream_frame(0, 1'b0);
        read_frame(0, -1);

        // random data with 1,0,0,1 and random back-pressure
        start_frame();
        make_frame(2);
        stream_frame(0, 1'b0);
        read_frame(1, -1);
        start_frame();
        make_frame(2);
        stream_frame(2, 1'b0);
        read_frame(2, -1);

        // large lanes that overflow DW
        start_frame();
        make_frame(3);
        stream_frame(0, 1'b0);
        read_frame(0, -1);

        // same data gapless and with a 5-cycle mid-row gap
        make_frame(2);
        start_frame();
        stream_frame(0, 1'b0);
        read_frame(0, -1);
        start_frame();
        stream_frame(1, 1'b0);
        read_frame(1, -1);

        // load mid-read, then a stray column after FULL sets ovf
        start_frame();
        make_frame(2);
        stream_frame(0, 1'b0);
        read_frame(0, 20);
        make_frame(2);
        stream_frame(0, 1'b1);
        check("ovf_after_full", int'(ovf), 1);
        read_frame(2, -1);
        check("ovf_sticky", int'(ovf), 1);
        start_frame();
        check("ovf_cleared_by_load", int'(ovf), 0);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
